rcswitch_rx: RTL and testbench

- Receiver and decoder for the RC-switch pulse protocol ("protocol 1"): sync pulse, then NBITS data bits, MSB first.
- Takes the raw demodulated 433 MHz receiver output and measures high/low durations in sample ticks.
- Classifies each duration as short (1T) or long (3T) and assembles the data word.
- Sits opposite the transmit path: a remote frame enters on in_i and leaves as data_o/valid_o.

---
 rtl/rcswitch_pkg.sv | 48 ++++
 rtl/rcswitch_rx_tick.sv | 46 ++++
 rtl/rcswitch_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rcswitch_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rcswitch_pkg.sv
// -----------------------------------------------------------------------------
// rcswitch_pkg
//   Shared types, constants and the pulse classifier for the RC-switch
//   "protocol 1" receiver.
//   - rx_state_e  : receiver state (IDLE waiting for sync, HIGH / LOW phase
//                   of a data bit).
//   - pulse_cls_e : classification of a measured phase length.
//   - Pulse-count constants are multiples of the nominal pulse length T.
// -----------------------------------------------------------------------------
package rcswitch_pkg;

  // Width of the phase-duration counter (saturates at 2**DUR_W-1 ticks).
  localparam int unsigned DUR_W               = 10;

  // Protocol-1 timing, in units of T.
  localparam int unsigned SYNC_LOW_PULSES     = 31;  // nominal sync low
  localparam int unsigned SYNC_MIN_PULSES     = 28;  // shortest low accepted as sync
  localparam int unsigned LONG_PULSES         = 3;   // long pulse = 3T
  localparam int unsigned LAST_TIMEOUT_PULSES = 4;   // last bit decided after 4T low

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } rx_state_e;

  typedef enum logic [1:0] {
    SHORT,
    LONG,
    BAD
  } pulse_cls_e;

  // Short = T +/- tol, long = 3T +/- tol, everything else (including glitches
  // shorter than the short window) is BAD. The lower bounds are written as
  // d + tol >= x so nothing underflows when tol > x.
  function automatic pulse_cls_e classify_pulse(input logic [DUR_W-1:0] dur,
                                                input int unsigned      pulse_ticks,
                                                input int unsigned      tol);
    int unsigned d;
    int unsigned long_nom;
    d        = 32'(dur);
    long_nom = LONG_PULSES * pulse_ticks;
    if ((d + tol >= pulse_ticks) && (d <= pulse_ticks + tol)) return SHORT;
    if ((d + tol >= long_nom) && (d <= long_nom + tol))       return LONG;
    return BAD;
  endfunction

endpackage

// File: rtl/rcswitch_rx_tick.sv
// -----------------------------------------------------------------------------
// rcswitch_rx_tick
//   Free-running sample-tick generator. tick_o is a one-cycle enable every
//   TICK_DIV clk_i cycles; it is never used as a clock.
//   Ports:
//     clk_i  : system clock
//     rst_i  : synchronous active-high reset (restarts the divider)
//     tick_o : one-cycle tick strobe
// -----------------------------------------------------------------------------
module rcswitch_rx_tick #(
  parameter int unsigned TICK_DIV = 1750
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/rcswitch_rx.sv
// -----------------------------------------------------------------------------
// rcswitch_rx
//   Receiver/decoder for RC-switch protocol 1. The raw demodulated RF level is
//   synchronised, its high/low phase lengths are measured in sample ticks and
//   classified as short (1T) or long (3T). A sync low arms the receiver, then
//   NBITS data bits are shifted in MSB first:
//     short high + long low  -> 0
//     long high  + short low -> 1
//   The final bit is decided by its high phase alone, either on the next
//   rising edge or after 4T of low, so the trailing gap of one frame can serve
//   as the sync of the next one.
//
//   Ports:
//     clk_i   : system clock
//     rst_i   : synchronous active-high reset
//     in_i    : raw RF data, asynchronous to clk_i
//     data_o  : last decoded frame, MSB = first bit received
//     valid_o : one-cycle strobe, data_o updated this cycle
//     err_o   : one-cycle strobe, frame aborted on a bad pulse
//
//   Optional feature (macro RCSWITCH_RX_REPEAT_FILTER_EN):
//     a decoded frame is only published when it equals the previous complete
//     frame and that frame ended at most 2*(sync+frame) ticks earlier. The
//     first copy is held internally; aborts clear the held copy.
// -----------------------------------------------------------------------------
module rcswitch_rx
  import rcswitch_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1750,
  parameter int unsigned PULSE_TICKS = 10,
  parameter int unsigned TOL         = 3,
  parameter int unsigned NBITS       = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  output logic [NBITS-1:0] data_o,
  output logic             valid_o,
  output logic             err_o
);

  localparam int unsigned BCW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] SHORT_MIN = DUR_W'(PULSE_TICKS - TOL);
  localparam logic [DUR_W-1:0] LONG_MAX  = DUR_W'(LONG_PULSES * PULSE_TICKS + TOL);
  localparam logic [DUR_W-1:0] SYNC_MIN  = DUR_W'(SYNC_MIN_PULSES * PULSE_TICKS);
  localparam logic [DUR_W-1:0] LAST_TO   = DUR_W'(LAST_TIMEOUT_PULSES * PULSE_TICKS);
  localparam logic [BCW-1:0]   LAST_BIT  = BCW'(NBITS - 1);

  // ---------------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------------
  logic tick;

  rcswitch_rx_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             in_s1_q, in_s2_q, in_d_q;   // 2-flop synchroniser + edge delay
  rx_state_e        state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  pulse_cls_e       hcls_q, hcls_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             rise, fall;
  pulse_cls_e       cls_now;
  logic             last_bit;
  logic             abort;
  logic             frame_done;
  logic [NBITS-1:0] frame_word;
  logic             publish;

  assign rise     = in_s2_q & ~in_d_q;
  assign fall     = ~in_s2_q & in_d_q;
  assign cls_now  = classify_pulse(dur_q, PULSE_TICKS, TOL);
  assign last_bit = (bit_cnt_q == LAST_BIT);

`ifdef RCSWITCH_RX_REPEAT_FILTER_EN
  // Window from the end of the held frame to the end of its repeat.
  localparam int unsigned REPEAT_WINDOW =
    2 * ((SYNC_LOW_PULSES + 1) + NBITS * (LONG_PULSES + 1)) * PULSE_TICKS;
  localparam int unsigned AGE_W = $clog2(REPEAT_WINDOW + 2);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(REPEAT_WINDOW);

  logic [NBITS-1:0] held_q, held_d;
  logic             held_vld_q, held_vld_d;
  logic [AGE_W-1:0] age_q, age_d;
`endif

  // ---------------------------------------------------------------------------
  // Phase-duration counter: restarts on every edge, counts ticks, saturates.
  // ---------------------------------------------------------------------------
  always_comb begin
    dur_d = dur_q;
    if (rise || fall) begin
      dur_d = '0;
    end else if (tick && (dur_q != DUR_MAX)) begin
      dur_d = dur_q + DUR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hcls_d     = hcls_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    abort      = 1'b0;
    frame_done = 1'b0;
    // The last bit depends only on the class of its high phase.
    frame_word = {sr_q[NBITS-2:0], (hcls_q == LONG)};

    unique case (state_q)
      IDLE: begin
        // Edges here only restart gap measurement; a rising edge after a
        // long enough low starts a frame.
        if (rise && (dur_q >= SYNC_MIN)) begin
          state_d   = HIGH;
          bit_cnt_d = '0;
          sr_d      = '0;
        end
      end

      HIGH: begin
        if (fall) begin
          if (cls_now == BAD) begin
            abort = 1'b1;
          end else begin
            hcls_d  = cls_now;
            state_d = LOW;
          end
        end else if (dur_q > LONG_MAX) begin
          abort = 1'b1;
        end
      end

      LOW: begin
        if (last_bit) begin
          if (rise) begin
            if (dur_q >= SHORT_MIN) frame_done = 1'b1;
            else                    abort      = 1'b1;
          end else if (dur_q >= LAST_TO) begin
            frame_done = 1'b1;
          end
        end else begin
          if (rise) begin
            if ((hcls_q == SHORT) && (cls_now == LONG)) begin
              sr_d      = {sr_q[NBITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + BCW'(1);
              state_d   = HIGH;
            end else if ((hcls_q == LONG) && (cls_now == SHORT)) begin
              sr_d      = {sr_q[NBITS-2:0], 1'b1};
              bit_cnt_d = bit_cnt_q + BCW'(1);
              state_d   = HIGH;
            end else begin
              abort = 1'b1;
            end
          end else if (dur_q > LONG_MAX) begin
            abort = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (frame_done || abort) begin
      state_d   = IDLE;
      sr_d      = '0;
      bit_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / repeat-filter logic
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef RCSWITCH_RX_REPEAT_FILTER_EN
    held_d     = held_q;
    held_vld_d = held_vld_q;
    age_d      = age_q;
    if (tick && (age_q != '1)) age_d = age_q + AGE_W'(1);
    publish = 1'b0;
    if (frame_done) begin
      publish    = held_vld_q && (frame_word == held_q) && (age_q <= AGE_LIMIT);
      held_d     = frame_word;
      held_vld_d = 1'b1;
      age_d      = '0;
    end
    if (abort) held_vld_d = 1'b0;
`else
    publish = frame_done;
`endif
    data_d  = publish ? frame_word : data_q;
    valid_d = publish;
    err_d   = abort;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_s1_q   <= 1'b0;
      in_s2_q   <= 1'b0;
      in_d_q    <= 1'b0;
      state_q   <= IDLE;
      dur_q     <= '0;
      hcls_q    <= SHORT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef RCSWITCH_RX_REPEAT_FILTER_EN
      held_q     <= '0;
      held_vld_q <= 1'b0;
      age_q      <= '0;
`endif
    end else begin
      in_s1_q   <= in_i;
      in_s2_q   <= in_s1_q;
      in_d_q    <= in_s2_q;
      state_q   <= state_d;
      dur_q     <= dur_d;
      hcls_q    <= hcls_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef RCSWITCH_RX_REPEAT_FILTER_EN
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      age_q      <= age_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rcswitch_rx.sv
// -----------------------------------------------------------------------------
// tb_rcswitch_rx
//   Directed bench for rcswitch_rx with TICK_DIV=4 (T = 40 clk cycles).
//   Inputs are driven on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_rcswitch_rx;

  localparam int unsigned TD    = 4;
  localparam int unsigned T_CYC = 10 * TD;  // clk cycles per nominal pulse T

`ifdef RCSWITCH_RX_REPEAT_FILTER_EN
  localparam int COPIES  = 2;  // a frame must repeat to be published
  localparam int B2B_EXP = 2;
`else
  localparam int COPIES  = 1;
  localparam int B2B_EXP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_in;
  logic [23:0] data_o;
  logic        valid_o;
  logic        err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Strobe monitor
  int unsigned n_valid = 0;
  int unsigned n_err   = 0;
  logic [23:0] last_data = '0;

  int unsigned v0, e0;

  always #5 clk = ~clk;

  rcswitch_rx #(
    .TICK_DIV (TD)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .in_i    (rf_in),
    .data_o  (data_o),
    .valid_o (valid_o),
    .err_o   (err_o)
  );

  always @(negedge clk) begin
    if (valid_o) begin
      n_valid   = n_valid + 1;
      last_data = data_o;
    end
    if (err_o) n_err = n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int cycles);
    rf_in = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Sync (1T high, 31T low) then 24 bits MSB first. Optional faults:
  // stretch_bit: high phase of that bit lasts 2T
  // glitch_bit : 1-clock high glitch 5 ticks into that bit's low phase
  // rst_bit    : rst pulsed early in that bit's high phase
  task automatic send_frame(input logic [23:0] w, input int stretch_bit,
                            input int glitch_bit, input int rst_bit);
    int hi, lo;
    drive(1'b1, T_CYC);
    drive(1'b0, 31 * T_CYC);
    for (int i = 0; i < 24; i++) begin
      hi = w[23-i] ? 3 : 1;
      lo = w[23-i] ? 1 : 3;
      if (i == stretch_bit) hi = 2;
      if (i == rst_bit) begin
        drive(1'b1, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        drive(1'b1, hi * T_CYC - 8);
      end else begin
        drive(1'b1, hi * T_CYC);
      end
      if (i == glitch_bit) begin
        drive(1'b0, 5 * TD);
        drive(1'b1, 1);
        drive(1'b0, lo * T_CYC - 5 * TD - 1);
      end else begin
        drive(1'b0, lo * T_CYC);
      end
    end
    rf_in = 1'b0;
  endtask

  // A clean transmission that must yield exactly one published frame.
  task automatic send_clean(input logic [23:0] w);
    for (int c = 0; c < COPIES; c++) send_frame(w, -1, -1, -1);
    drive(1'b0, 60 * TD);
  endtask

  initial begin
    rst   = 1'b1;
    rf_in = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("reset_data", 32'(data_o), 32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_err", 32'(err_o), 32'h0);

    // Single frame 0xA5A5A5
    v0 = n_valid; e0 = n_err;
    send_clean(24'hA5A5A5);
    check("single_valid_cnt", n_valid - v0, 1);
    check("single_data", 32'(data_o), 32'hA5A5A5);
    check("single_err_cnt", n_err - e0, 0);

    // Three back-to-back copies (fresh filter state)
    do_reset();
    check("b2b_reset_data", 32'(data_o), 32'h0);
    v0 = n_valid; e0 = n_err;
    for (int k = 0; k < 3; k++) send_frame(24'hA5A5A5, -1, -1, -1);
    drive(1'b0, 60 * TD);
    check("b2b_valid_cnt", n_valid - v0, B2B_EXP);
    check("b2b_last_data", 32'(last_data), 32'hA5A5A5);
    check("b2b_err_cnt", n_err - e0, 0);

    // Bit 5 high stretched to 2T -> abort, data kept
    v0 = n_valid; e0 = n_err;
    send_frame(24'hA5A5A5, 5, -1, -1);
    drive(1'b0, 60 * TD);
    check("stretch_err_cnt", n_err - e0, 1);
    check("stretch_valid_cnt", n_valid - v0, 0);
    check("stretch_data_kept", 32'(data_o), 32'hA5A5A5);
    v0 = n_valid; e0 = n_err;
    send_clean(24'h000001);
    check("after_stretch_valid", n_valid - v0, 1);
    check("after_stretch_data", 32'(data_o), 32'h000001);
    check("after_stretch_err", n_err - e0, 0);

    // 1-clock glitch in bit 10 low phase -> abort
    v0 = n_valid; e0 = n_err;
    send_frame(24'h5A5A5A, -1, 10, -1);
    drive(1'b0, 60 * TD);
    check("glitch_err_cnt", n_err - e0, 1);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_data_kept", 32'(data_o), 32'h000001);
    v0 = n_valid; e0 = n_err;
    send_clean(24'h5A5A5A);
    check("after_glitch_valid", n_valid - v0, 1);
    check("after_glitch_data", 32'(data_o), 32'h5A5A5A);

    // Reset during bit 12; resumed frame must be ignored
    v0 = n_valid; e0 = n_err;
    send_frame(24'h123456, -1, -1, 12);
    drive(1'b0, 60 * TD);
    check("resumed_valid_cnt", n_valid - v0, 0);
    check("resumed_err_cnt", n_err - e0, 0);
    check("resumed_data", 32'(data_o), 32'h0);
    v0 = n_valid; e0 = n_err;
    send_clean(24'hFFFFFF);
    check("after_rst_valid", n_valid - v0, 1);
    check("after_rst_data", 32'(data_o), 32'hFFFFFF);
    check("after_rst_err", n_err - e0, 0);

    // High held 2000 ticks after sync -> timeout abort; then long low
    v0 = n_valid; e0 = n_err;
    drive(1'b1, T_CYC);
    drive(1'b0, 31 * T_CYC);
    drive(1'b1, 2000 * TD);
    check("timeout_err_cnt", n_err - e0, 1);
    drive(1'b0, 1100 * TD);
    check("long_low_dur_sat", 32'(dut.dur_q), 32'd1023);
    check("long_low_valid_cnt", n_valid - v0, 0);
    check("long_low_err_cnt", n_err - e0, 1);
    check("long_low_data", 32'(data_o), 32'hFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
